// File: rtl/cache_pkg.sv
// Shared definitions for the cache-to-memory line bridge: state encoding and
// the default line/beat geometry used by both the cache and the bridge.
package cache_pkg;

    localparam int unsigned BridgeAwidth = 27;
    localparam int unsigned BridgeDwidth = 32;
    localparam int unsigned BridgeBeats  = 4;
    localparam int unsigned ByteBits     = $clog2(BridgeDwidth / 8);
    localparam int unsigned LineBits     = $clog2(BridgeBeats);
    localparam int unsigned LineFieldW   = BridgeAwidth - ByteBits - LineBits;

    typedef enum bit [2:0] {
        B_IDLE,
        B_CMD,
        B_RWAIT,
        B_ACK,
        B_END,
        B_DRAIN
    } bridge_state_t;

endpackage

// File: rtl/if_wb.sv
// Wishbone-style bus between the cache (master) and the line bridge (slave).
interface if_wb #(
    parameter int unsigned DWIDTH = 32
) ();

    logic              cyc;
    logic              stb;
    logic              we;
    logic [31:0]       adr;
    logic [DWIDTH-1:0] dat_m;
    logic [DWIDTH/8-1:0] sel;
    logic              ack;
    logic              stall;
    logic [DWIDTH-1:0] dat_s;

    modport master (
        output cyc, stb, we, adr, dat_m, sel,
        input  ack, stall, dat_s
    );

    modport slave (
        input  cyc, stb, we, adr, dat_m, sel,
        output ack, stall, dat_s
    );

endinterface

// File: rtl/cache_line_bridge.sv
// Turns a cache line burst on the wishbone bus into per-word memory commands,
// generating beat addresses from the latched line address and acking each beat.
module cache_line_bridge
    import cache_pkg::*;
#(
    parameter int unsigned AWIDTH   = BridgeAwidth,
    parameter int unsigned DWIDTH   = BridgeDwidth,
    parameter int unsigned BEATS    = BridgeBeats,
    localparam int unsigned BYTEBITS = $clog2(DWIDTH / 8),
    localparam int unsigned LBITS    = $clog2(BEATS),
    localparam int unsigned LINEW    = AWIDTH - BYTEBITS - LBITS
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    if_wb.slave                        cbus,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [AWIDTH-BYTEBITS-1:0] mem_adr,
    output logic [DWIDTH-1:0]          mem_wdat,
    output logic [DWIDTH/8-1:0]        mem_be,
    input  logic                       mem_wait,
    input  logic [DWIDTH-1:0]          mem_rdat,
    input  logic                       mem_rvalid
);

    bridge_state_t     state_q, state_d;
    logic [LBITS-1:0]  beat_q, beat_d;
    logic [LINEW-1:0]  line_q, line_d;
    logic              we_q, we_d;
    logic [DWIDTH-1:0] dat_s_q, dat_s_d;
    logic              ack;

    // Bits the bridge deliberately ignores: byte lanes, offset within the line,
    // and address bits above the memory space.
    logic unused_bits;
    assign unused_bits = ^{cbus.sel, cbus.adr[31:AWIDTH], cbus.adr[BYTEBITS+LBITS-1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= B_IDLE;
            beat_q  <= '0;
            line_q  <= '0;
            we_q    <= 1'b0;
            dat_s_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            we_q    <= we_d;
            dat_s_q <= dat_s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        we_d    = we_q;
        dat_s_d = dat_s_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ack     = 1'b0;

        unique case (state_q)
            B_IDLE: begin
                if (cbus.cyc && cbus.stb) begin
                    line_d  = cbus.adr[AWIDTH-1:BYTEBITS+LBITS];
                    we_d    = cbus.we;
                    beat_d  = '0;
                    state_d = B_CMD;
                end
            end
            B_CMD: begin
                if (!cbus.cyc) begin
                    state_d = B_IDLE;
                end else if (cbus.stb) begin
                    mem_req = 1'b1;
                    mem_we  = we_q;
                    if (!mem_wait) begin
                        state_d = we_q ? B_ACK : B_RWAIT;
                    end
                end
            end
            B_RWAIT: begin
                // An accepted read must still be absorbed if the cache walks away.
                if (!cbus.cyc) begin
                    state_d = mem_rvalid ? B_IDLE : B_DRAIN;
                end else if (mem_rvalid) begin
                    dat_s_d = mem_rdat;
                    state_d = B_ACK;
                end
            end
            B_ACK: begin
                if (!cbus.cyc) begin
                    state_d = B_IDLE;
                end else begin
                    ack = 1'b1;
                    if (beat_q == LBITS'(BEATS - 1)) begin
                        state_d = B_END;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = B_CMD;
                    end
                end
            end
            B_END: begin
                if (!cbus.cyc) begin
                    state_d = B_IDLE;
                end
            end
            B_DRAIN: begin
                if (mem_rvalid) begin
                    state_d = B_IDLE;
                end
            end
            default: state_d = B_IDLE;
        endcase
    end

    assign cbus.ack   = ack;
    assign cbus.stall = 1'b0;
    assign cbus.dat_s = dat_s_q;
    assign mem_adr    = {line_q, beat_q};
    assign mem_wdat   = cbus.dat_m;
    assign mem_be     = '1;

endmodule
